// File: rtl/spi_master_arb.sv
// Two-requester SPI master: round-robin arbitration, then one 8-bit mode-style
// transfer per cs-low window (mosi launched and miso captured on sclk falling edges).
module spi_master_arb #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] grant,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [7:0] HC_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] hc;
  logic [3:0] hp;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic       ptr;
  logic       owner;
  logic       win;
  logic [7:0] win_byte;

  always_comb begin
    win      = (req == 2'b11) ? ptr : req[1];
    win_byte = win ? tx_data1 : tx_data0;
  end

  // bit 7 goes straight to mosi at grant; tx_sr holds the remaining seven bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hc      <= '0;
      hp      <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      grant   <= '0;
      done    <= 1'b0;
      rx_data <= '0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state <= SETUP;
            hc    <= '0;
            owner <= win;
            grant <= win ? 2'b10 : 2'b01;
            tx_sr <= win_byte[6:0];
            mosi  <= win_byte[7];
            cs    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (hc == HC_LAST) begin
            hc    <= '0;
            hp    <= '0;
            sclk  <= 1'b1;
            state <= XFER;
          end else begin
            hc <= hc + 8'd1;
          end
        end
        XFER: begin
          if (hc == HC_LAST) begin
            hc <= '0;
            hp <= hp + 4'd1;
            // half-period 15 is the low tail after the 8th falling edge
            if (hp == 4'd15) begin
              state <= HOLD;
            end else begin
              sclk <= ~sclk;
              if (sclk) begin
                rx_sr <= {rx_sr[6:0], miso};
                if (hp != 4'd14) begin
                  mosi  <= tx_sr[6];
                  tx_sr <= {tx_sr[5:0], 1'b0};
                end
              end
            end
          end else begin
            hc <= hc + 8'd1;
          end
        end
        HOLD: begin
          if (hc == HC_LAST) begin
            hc      <= '0;
            cs      <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sr;
            grant   <= '0;
            ptr     <= ~owner;
            state   <= GAP;
          end else begin
            hc <= hc + 8'd1;
          end
        end
        GAP: begin
          if (hc == HC_LAST) begin
            hc    <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hc <= hc + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Randomized scoreboard bench for spi_master_arb with a bit-level SPI slave model.
module tb_spi_master_arb;

  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] tx_data0 = 8'h00;
  logic [7:0] tx_data1 = 8'h00;
  logic       miso = 1'b0;
  logic [1:0] grant;
  logic       done;
  logic [7:0] rx_data;
  logic       busy, sclk, cs, mosi;

  spi_master_arb #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic        mptr = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, want);
    end
  endfunction

  // monitor + slave model, sampled mid-cycle
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0, prev_done = 1'b0;
  logic [7:0]  cap_tx = 8'h00, sreg = 8'h00;
  logic [1:0]  cap_g = 2'b00;
  int          falls = 0, rises = 0;
  int unsigned fall_cyc = 0, rise_cyc = 0;
  bit          have_rise = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      falls = 0; rises = 0; have_rise = 1'b0; miso = 1'b0;
    end else begin
      if ((sclk !== prev_sclk && cs && prev_cs) || grant == 2'b11 ||
          (!busy && (grant != 2'b00 || !cs || sclk)) || (!cs && !busy) ||
          (!cs && !prev_cs && grant !== cap_g)) begin
        checks++;
        failures++;
        $display("FAIL invariant cs=%b sclk=%b busy=%b grant=%b cap_grant=%b", cs, sclk, busy, grant, cap_g);
      end else begin
        checks++;
      end
      if (prev_cs && !cs) begin
        cap_g = grant; cap_tx = 8'h00; falls = 0; rises = 0; fall_cyc = cyc;
        sreg = (exp_q.size() != 0) ? exp_q[0].rx : 8'h00;
        miso = sreg[7];
        if (have_rise) chk("cs_high_gap_ok", 32'(cyc - rise_cyc >= CD + 1), 1);
      end
      if (!prev_cs && cs) begin
        rise_cyc = cyc; have_rise = 1'b1;
      end
      if (prev_sclk && !sclk) begin
        falls++;
        cap_tx = {cap_tx[6:0], prev_mosi};
        sreg = {sreg[6:0], 1'b0};
        miso = sreg[7];
      end
      if (!prev_sclk && sclk) rises++;
      if (done) begin
        exp_t e;
        chk("done_one_cycle", 32'(prev_done), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(cap_g), 32'(e.g));
          chk("mosi_byte", 32'(cap_tx), 32'(e.tx));
          chk("rx_data", 32'(rx_data), 32'(e.rx));
          chk("sclk_falls", 32'(falls), 8);
          chk("sclk_rises", 32'(rises), 8);
          chk("cs_to_done", cyc - fall_cyc, 18 * CD);
        end
      end
    end
    prev_sclk = sclk; prev_cs = cs; prev_mosi = mosi; prev_done = done;
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    if (!ok) chk("idle_wait", 0, 1);
  endtask

  task automatic do_xfer(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] sb, input bit drop, input bit scram,
                         output int unsigned lat);
    exp_t        e;
    logic        w;
    bit          seen = 1'b0;
    int unsigned c0;
    wait_idle();
    w    = (r == 2'b11) ? mptr : r[1];
    e.g  = w ? 2'b10 : 2'b01;
    e.tx = w ? d1 : d0;
    e.rx = sb;
    exp_q.push_back(e);
    tx_data0 = d0; tx_data1 = d1; req = r; c0 = cyc;
    for (int i = 0; i < 40 * CD + 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (drop && falls >= 2) req = 2'b00;
      if (scram && !cs && falls >= 1) begin
        tx_data0 = ~d0; tx_data1 = ~d1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    lat  = cyc - c0;
    req  = 2'b00;
    mptr = ~w;
    repeat (CD + 3) @(negedge clk);
    chk("back_to_idle", {busy, cs, grant}, 4'b0100);
  endtask

  initial begin
    int unsigned lat;
    int          n;
    bit          hit;
    exp_t        e;

    #1 rst = 1'b1;
    #1;
    chk("reset_state", {cs, sclk, mosi, grant, done, busy, rx_data}, {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_xfer(2'b01, 8'hA5, 8'h00, 8'h3C, 1'b0, 1'b0, lat);
    chk("latency_basic", lat, 1 + 18 * CD);

    do_xfer(2'b10, 8'h00, 8'hF0, 8'h96, 1'b0, 1'b1, lat);
    chk("latency_scramble", lat, 1 + 18 * CD);

    // continuous request from both: alternates starting with the pointed side
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      e.g  = mptr ? 2'b10 : 2'b01;
      e.tx = mptr ? 8'h22 : 8'h11;
      e.rx = 8'(8'h40 + i);
      exp_q.push_back(e);
      mptr = ~mptr;
    end
    tx_data0 = 8'h11; tx_data1 = 8'h22; req = 2'b11;
    n = 0;
    for (int i = 0; i < 4 * (20 * CD + 10) && n < 4; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    req = 2'b00;
    chk("continuous_dones", 32'(n), 4);
    repeat (CD + 3) @(negedge clk);
    chk("continuous_idle", {busy, cs}, 2'b01);

    do_xfer(2'b01, 8'hC3, 8'h5A, 8'h7E, 1'b1, 1'b0, lat);
    chk("latency_drop", lat, 1 + 18 * CD);
    repeat (3 * CD) @(negedge clk);
    chk("no_restart_after_drop", {busy, cs}, 2'b01);

    // reset after the 4th falling edge aborts the transfer
    wait_idle();
    e.g = 2'b01; e.tx = 8'h99; e.rx = 8'hE7;
    exp_q.push_back(e);
    tx_data0 = 8'h99; req = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 40 * CD && !hit; i++) begin
      @(negedge clk);
      if (falls >= 4) hit = 1'b1;
    end
    chk("reached_4_falls", 32'(hit), 1);
    rst = 1'b1;
    #1;
    chk("reset_abort", {cs, sclk, done, busy, grant, rx_data}, {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00});
    exp_q.delete();
    mptr = 1'b0;
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * CD) @(negedge clk);
    chk("post_reset_idle", {busy, cs, rx_data}, {1'b0, 1'b1, 8'h00});
    do_xfer(2'b10, 8'h12, 8'h34, 8'hA9, 1'b0, 1'b0, lat);
    chk("latency_post_reset", lat, 1 + 18 * CD);

    for (int t = 0; t < 16; t++) begin
      do_xfer(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), lat);
      chk("latency_rand", lat, 1 + 18 * CD);
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
